// File: rtl/articolor_pkg.sv
// articolor_pkg -- shared types and defaults for the artifact-colour controller.
//   state_e : controller FSM states (OFF, ARM, ON, DISARM)
//   px_e    : per-pixel class (neither / white / black)
//   frame_e : per-frame class decided at the vs rising edge
//   MODE_*  : encodings of the 2-bit mode input (1x = auto)
//   *_DEF   : default classification thresholds and frame counts
//   sat_inc : 16-bit saturating increment
package articolor_pkg;

  typedef enum logic [1:0] {ST_OFF, ST_ARM, ST_ON, ST_DISARM} state_e;
  typedef enum logic [1:0] {PX_NONE, PX_WHITE, PX_BLACK}      px_e;
  typedef enum logic [1:0] {FR_HOLD, FR_ART, FR_CLEAN}        frame_e;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ON   = 2'b01;
  localparam logic [1:0] MODE_AUTO = 2'b10;

  localparam int LUMA_HI_DEF    = 238;
  localparam int THRESH_ON_DEF  = 2048;
  localparam int THRESH_OFF_DEF = 256;
  localparam int FRAMES_ON_DEF  = 4;
  localparam int FRAMES_OFF_DEF = 8;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/articolor_detect.sv
// articolor_detect -- pixel classification and W-B-W / B-W-B triplet detection.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   ce_i              : pixel clock enable
//   r_i, g_i, b_i     : pixel colour
//   blank_i           : hbl | vbl; clears the history so triplets never span blanking
//   trip_o            : combinational strobe, a triplet completes on this ce_i
//   mid_white_o       : the triplet's middle pixel is white (else black)
module articolor_detect import articolor_pkg::*; #(
  parameter int LUMA_HI = LUMA_HI_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  input  logic       blank_i,
  output logic       trip_o,
  output logic       mid_white_o
);

  localparam logic [7:0] LUMA = 8'(LUMA_HI);

  px_e cur;
  px_e h1_q, h2_q;  // h1 = previous pixel, h2 = the one before

  always_comb begin
    cur = PX_NONE;
    if (r_i >= LUMA && g_i >= LUMA && b_i >= LUMA)
      cur = PX_WHITE;
    else if (r_i == 8'd0 && g_i == 8'd0 && b_i == 8'd0)
      cur = PX_BLACK;
  end

  assign trip_o = ce_i & ~blank_i &
                  (((h2_q == PX_WHITE) && (h1_q == PX_BLACK) && (cur == PX_WHITE)) ||
                   ((h2_q == PX_BLACK) && (h1_q == PX_WHITE) && (cur == PX_BLACK)));
  assign mid_white_o = (h1_q == PX_WHITE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h1_q <= PX_NONE;
      h2_q <= PX_NONE;
    end else if (ce_i) begin
      if (blank_i) begin
        h1_q <= PX_NONE;
        h2_q <= PX_NONE;
      end else begin
        h2_q <= h1_q;
        h1_q <= cur;
      end
    end
  end

endmodule

// File: rtl/articolor_ctrl.sv
// articolor_ctrl -- decides per frame whether composite artifact colouring is on.
//   clk, reset          : clock, synchronous active-high reset
//   ce_pix              : pixel clock enable; all state moves only on it
//   mode                : 00 forced off, 01 forced on, 1x auto
//   r_in, g_in, b_in    : pixel colour
//   hbl_in, vbl_in      : blanking; hs_in, vs_in : syncs (vs rise = frame boundary)
//   enable              : registered artifact-colour enable
//   phase_inv           : artifact phase inversion
//   frame_cnt           : triplet count latched at the last frame boundary
// Optional: define ARTICOLOR_CTRL_PHASE_EN to build the column-parity tracking
// that drives phase_inv; otherwise phase_inv is tied low.
module articolor_ctrl import articolor_pkg::*; #(
  parameter int LUMA_HI    = LUMA_HI_DEF,
  parameter int THRESH_ON  = THRESH_ON_DEF,
  parameter int THRESH_OFF = THRESH_OFF_DEF,
  parameter int FRAMES_ON  = FRAMES_ON_DEF,
  parameter int FRAMES_OFF = FRAMES_OFF_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic [1:0]  mode,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  input  logic        hbl_in,
  input  logic        vbl_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic        enable,
  output logic        phase_inv,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] TH_ON  = 16'(THRESH_ON);
  localparam logic [15:0] TH_OFF = 16'(THRESH_OFF);
  localparam logic [4:0]  FR_ON  = 5'(FRAMES_ON);
  localparam logic [4:0]  FR_OFF = 5'(FRAMES_OFF);

  logic        blank, trip, mid_white, vs_rise;
  logic        vs_q, sync_q, enable_q;
  logic [15:0] cnt_q, frame_cnt_q;
  logic [3:0]  fc_q;
  logic [4:0]  fc_inc;
  state_e      state_q;
  frame_e      fcls;

  assign blank   = hbl_in | vbl_in;
  assign vs_rise = vs_in & ~vs_q;
  assign fc_inc  = {1'b0, fc_q} + 5'd1;

  articolor_detect #(.LUMA_HI(LUMA_HI)) u_detect (
    .clk_i      (clk),
    .rst_i      (reset),
    .ce_i       (ce_pix),
    .r_i        (r_in),
    .g_i        (g_in),
    .b_i        (b_in),
    .blank_i    (blank),
    .trip_o     (trip),
    .mid_white_o(mid_white)
  );

  always_comb begin
    fcls = FR_HOLD;
    if (cnt_q >= TH_ON)      fcls = FR_ART;
    else if (cnt_q < TH_OFF) fcls = FR_CLEAN;
  end

  // Triplet counter. Nothing is counted until the first vs rise after reset
  // (sync_q), so a frame interrupted by reset never gets classified.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q        <= 1'b0;
      sync_q      <= 1'b0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
    end else if (ce_pix) begin
      vs_q <= vs_in;
      if (vs_rise) begin
        sync_q      <= 1'b1;
        frame_cnt_q <= cnt_q;
        cnt_q       <= '0;  // a triplet landing on the boundary is dropped
      end else if (trip && sync_q) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

`ifdef ARTICOLOR_CTRL_PHASE_EN
  logic        hs_q, par_q, mid_par_q, phase_q;
  logic [15:0] even_q, odd_q;
  logic        trip_even;

  // White middle on column 0 / black middle on column 1 is the "even" alignment.
  assign trip_even = mid_white ? ~mid_par_q : mid_par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q      <= 1'b0;
      par_q     <= 1'b0;
      mid_par_q <= 1'b0;
      even_q    <= '0;
      odd_q     <= '0;
    end else if (ce_pix) begin
      hs_q <= hs_in;
      if (hs_in && !hs_q) par_q <= 1'b0;
      else if (!blank)    par_q <= ~par_q;
      // par_q is the current pixel's column parity; it becomes the middle next time
      if (!blank) mid_par_q <= par_q;
      if (vs_rise) begin
        even_q <= '0;
        odd_q  <= '0;
      end else if (trip && sync_q) begin
        if (trip_even) even_q <= sat_inc(even_q);
        else           odd_q  <= sat_inc(odd_q);
      end
    end
  end

  assign phase_inv = phase_q;
`else
  logic unused_phase;
  assign unused_phase = hs_in ^ mid_white;
  assign phase_inv    = 1'b0;
`endif

  // Frame FSM plus registered outputs; it runs in every mode so switching
  // back to auto picks up the current classification immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_OFF;
      fc_q     <= '0;
      enable_q <= 1'b0;
`ifdef ARTICOLOR_CTRL_PHASE_EN
      phase_q  <= 1'b0;
`endif
    end else if (ce_pix) begin
      if (vs_rise) begin
        case (state_q)
          ST_OFF: if (fcls == FR_ART) begin
            state_q <= ST_ARM;
            fc_q    <= 4'd1;
          end
          ST_ARM: if (fcls == FR_ART) begin
            fc_q <= fc_inc[3:0];
            if (fc_inc >= FR_ON) state_q <= ST_ON;
          end else begin
            state_q <= ST_OFF;
          end
          ST_ON: if (fcls == FR_CLEAN) begin
            state_q <= ST_DISARM;
            fc_q    <= 4'd1;
          end
          ST_DISARM: if (fcls == FR_ART) begin
            state_q <= ST_ON;
          end else if (fcls == FR_CLEAN) begin
            fc_q <= fc_inc[3:0];
            if (fc_inc >= FR_OFF) state_q <= ST_OFF;
          end
          default: state_q <= ST_OFF;
        endcase
`ifdef ARTICOLOR_CTRL_PHASE_EN
        if (fcls == FR_ART) begin
          if (odd_q > even_q)      phase_q <= 1'b1;
          else if (even_q > odd_q) phase_q <= 1'b0;
        end
`endif
      end
      case (mode)
        MODE_OFF: enable_q <= 1'b0;
        MODE_ON:  enable_q <= 1'b1;
        default:  enable_q <= (state_q == ST_ON) || (state_q == ST_DISARM);
      endcase
    end
  end

  assign enable    = enable_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_articolor_ctrl.sv
// tb_articolor_ctrl -- directed bench for articolor_ctrl with small thresholds
// (THRESH_ON=64, THRESH_OFF=8) so frames stay short. One long line saturates
// the 16-bit triplet counter. Honours ARTICOLOR_CTRL_PHASE_EN for phase_inv.
module tb_articolor_ctrl;
  import articolor_pkg::*;

  logic        clk = 1'b0;
  logic        reset, ce_pix;
  logic [1:0]  mode;
  logic [7:0]  r_in, g_in, b_in;
  logic        hbl_in, vbl_in, hs_in, vs_in;
  logic        enable, phase_inv;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ARTICOLOR_CTRL_PHASE_EN
  localparam logic PH = 1'b1;
`else
  localparam logic PH = 1'b0;
`endif

  // {hbl, rgb}: classification edges and a W-B | W-B-W split across hbl.
  localparam logic [24:0] TAB [12] = '{
    {1'b0, 24'hFFFFFF}, {1'b0, 24'h000000}, {1'b1, 24'h000000},
    {1'b0, 24'hEEEEEE}, {1'b0, 24'h000000}, {1'b0, 24'hFFFFFF},
    {1'b0, 24'h000001}, {1'b0, 24'hFFFFFF}, {1'b0, 24'hFFFFED},
    {1'b0, 24'h000000}, {1'b0, 24'hFFFFFF}, {1'b0, 24'h000000}
  };

  always #5 clk = ~clk;

  articolor_ctrl #(.THRESH_ON(64), .THRESH_OFF(8)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .mode(mode),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hbl_in(hbl_in), .vbl_in(vbl_in), .hs_in(hs_in), .vs_in(vs_in),
    .enable(enable), .phase_inv(phase_inv), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic hb, input logic vb, input logic hs, input logic vs);
    r_in = r; g_in = g; b_in = b;
    hbl_in = hb; vbl_in = vb; hs_in = hs; vs_in = vs;
    ce_pix = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    ce_pix = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind 0: W-B alternating from white, 1: from black, 2: solid black
  task automatic line(input int n, input int kind);
    logic [7:0] v;
    px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (kind == 2) v = 8'h00;
      else           v = ((i % 2 == 0) == (kind == 0)) ? 8'hFF : 8'h00;
      px(v, v, v, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vsync();
    px(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    px(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    px(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic frame(input int lines, input int n, input int kind);
    for (int l = 0; l < lines; l++) line(n, kind);
    vsync();
  endtask

  initial begin
    reset = 1'b1; ce_pix = 1'b0; mode = MODE_AUTO;
    r_in = '0; g_in = '0; b_in = '0;
    hbl_in = 1'b1; vbl_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    repeat (3) px(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_en", 16'(enable), 16'd0);
    chk("rst_ph", 16'(phase_inv), 16'd0);
    chk("rst_fc", frame_cnt, 16'd0);
    reset = 1'b0;
    vsync();

    // four artifact frames, the last one saturating the counter
    frame(2, 40, 0);
    chk("a1_fc", frame_cnt, 16'd76);
    chk("a1_en", 16'(enable), 16'd0);
    frame(2, 40, 0);
    frame(2, 40, 0);
    chk("a3_en", 16'(enable), 16'd0);
    frame(1, 65600, 0);
    chk("a4_en", 16'(enable), 16'd1);
    chk("a4_sat", frame_cnt, 16'd65535);
    chk("a4_ph", 16'(phase_inv), 16'd0);

    // ON -> DISARM, artifact at clean frame 5, then 8 clean frames
    frame(2, 40, 2);
    chk("blk_fc", frame_cnt, 16'd0);
    chk("blk_en", 16'(enable), 16'd1);
    repeat (3) frame(1, 10, 2);
    frame(2, 40, 0);
    chk("rearm_en", 16'(enable), 16'd1);
    repeat (7) frame(1, 10, 2);
    chk("c7_en", 16'(enable), 16'd1);
    frame(1, 10, 2);
    chk("c8_en", 16'(enable), 16'd0);

    // ARM after 2 artifact frames, then a hold frame
    frame(2, 40, 0);
    frame(2, 40, 0);
    frame(1, 20, 0);
    chk("hold_fc", frame_cnt, 16'd18);
    chk("hold_en", 16'(enable), 16'd0);
    repeat (3) frame(2, 40, 0);
    chk("arm3_en", 16'(enable), 16'd0);
    frame(2, 40, 0);
    chk("arm4_en", 16'(enable), 16'd1);

    // phase: shifted, balanced, aligned, shifted-but-hold
    frame(2, 40, 1);
    chk("sh_ph", 16'(phase_inv), 16'(PH));
    line(40, 0);
    line(40, 1);
    vsync();
    chk("eq_ph", 16'(phase_inv), 16'(PH));
    frame(2, 40, 0);
    chk("ws_ph", 16'(phase_inv), 16'd0);
    frame(1, 20, 1);
    chk("hold_ph", 16'(phase_inv), 16'd0);

    // mode overrides and ce_pix gating
    mode = MODE_OFF;
    px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("m00_en", 16'(enable), 16'd0);
    mode = MODE_ON;
    idle(3);
    chk("ce0_en", 16'(enable), 16'd0);
    px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("m01_en", 16'(enable), 16'd1);
    mode = 2'b11;
    px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("m11_en", 16'(enable), 16'd1);
    mode = MODE_OFF;
    repeat (8) frame(1, 10, 2);
    chk("m00run_en", 16'(enable), 16'd0);
    mode = MODE_AUTO;
    px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("auto_en", 16'(enable), 16'd0);
    mode = MODE_ON;
    px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("m01off_en", 16'(enable), 16'd1);
    mode = MODE_AUTO;

    // back to ON with phase_inv set, then reset mid-frame
    repeat (3) frame(2, 40, 0);
    frame(2, 40, 1);
    chk("on2_en", 16'(enable), 16'd1);
    chk("on2_ph", 16'(phase_inv), 16'(PH));
    line(40, 0);
    reset = 1'b1;
    px(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstm_en", 16'(enable), 16'd0);
    chk("rstm_ph", 16'(phase_inv), 16'd0);
    chk("rstm_fc", frame_cnt, 16'd0);
    reset = 1'b0;
    line(40, 0);
    line(40, 0);
    vsync();
    chk("discard_fc", frame_cnt, 16'd0);

    // classification thresholds and hbl-split pattern
    px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++)
      px(TAB[i][23:16], TAB[i][15:8], TAB[i][7:0], TAB[i][24], 1'b0, 1'b0, 1'b0);
    vsync();
    chk("hbl_fc", frame_cnt, 16'd2);
    chk("hbl_en", 16'(enable), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/articolor_ctrl.md
ARTICOLOR_CTRL -- requirements
Module: articolor_ctrl

Interface
REQ-001 SHALL have parameter LUMA_HI, default 238, as the minimum per-channel value that classifies a pixel as white.
REQ-002 SHALL have parameter THRESH_ON, default 2048, as the minimum triplet count that classifies a frame as artifact.
REQ-003 SHALL have parameter THRESH_OFF, default 256, as the count below which a frame is classified as clean.
REQ-004 SHALL have parameter FRAMES_ON, default 4, as the number of consecutive artifact frames needed to enter ON.
REQ-005 SHALL have parameter FRAMES_OFF, default 8, as the number of consecutive clean frames needed to return to OFF.
REQ-006 SHALL have port clk, input, 1 bit, the single clock.
REQ-007 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 SHALL have port ce_pix, input, 1 bit, the pixel clock enable.
REQ-009 SHALL have port mode, input, 2 bits: 00 forced off, 01 forced on, 1x auto.
REQ-010 SHALL have ports r_in, g_in and b_in, inputs, 8 bits each, the pixel colour.
REQ-011 SHALL have ports hbl_in, vbl_in, hs_in and vs_in, inputs, 1 bit each, the blanking and sync signals.
REQ-012 SHALL have port enable, output, 1 bit, the artifact-colour enable for the colour block.
REQ-013 SHALL have port phase_inv, output, 1 bit, which inverts the artifact phase.
REQ-014 SHALL have port frame_cnt, output, 16 bits, the triplet count latched at the last frame boundary.

Function
REQ-015 SHALL take all state changes only on clk edges where ce_pix=1, except reset.
REQ-016 SHALL classify a pixel as white when all three channels are >= LUMA_HI, and as black when all three channels are 0.
REQ-017 SHALL keep a 2-deep pixel history that is cleared to "neither" whenever hbl_in or vbl_in is 1, so that every triplet lies inside active video.
REQ-018 SHALL count a triplet when the history and the current pixel form W-B-W or B-W-B, using a 16-bit counter that saturates at 65535.
REQ-019 SHALL toggle a column-parity bit on each active pixel and clear it to 0 on a rising edge of hs_in.
REQ-020 SHALL record the parity of each triplet's middle pixel, with a white middle at parity 0 or a black middle at parity 1 counting as even, and every other triplet counting as odd, each in a 16-bit saturating counter.
REQ-021 SHALL treat a rising edge of vs_in (registered vs_in=0, current vs_in=1) as the frame boundary.
REQ-022 SHALL classify the frame at the boundary as artifact (count >= THRESH_ON), clean (count < THRESH_OFF) or hold (anything else).
REQ-023 SHALL at the boundary latch the count into frame_cnt and clear the triplet, even and odd counters; a triplet completing on that same ce_pix SHALL be discarded.
REQ-024 SHALL run the FSM states OFF, ARM, ON and DISARM, advanced only at frame boundaries, with a 4-bit frame counter fc.
REQ-025 SHALL in OFF go to ARM with fc=1 on an artifact frame, and stay in OFF otherwise.
REQ-026 SHALL in ARM on an artifact frame increment fc and go to ON when fc+1 >= FRAMES_ON, and on a clean or hold frame go to OFF.
REQ-027 SHALL in ON go to DISARM with fc=1 on a clean frame, and stay in ON otherwise.
REQ-028 SHALL in DISARM go to ON on an artifact frame, increment fc on a clean frame and go to OFF when fc+1 >= FRAMES_OFF, and hold state and fc on a hold frame.
REQ-029 SHALL register enable as 0 when mode=00, 1 when mode=01, and (state is ON or DISARM) when mode=1x, updated on each ce_pix with 1 ce_pix latency.
REQ-030 SHALL keep the FSM running in every mode, so that returning to auto takes effect at once.
REQ-031 SHALL at an artifact-frame boundary set phase_inv to 1 if odd > even and to 0 if even > odd, and hold it when they are equal or the frame is not artifact.

Reset
REQ-032 SHALL on reset=1 set state OFF, fc=0, enable=0, phase_inv=0, frame_cnt=0, all counters 0, the history to "neither", parity 0 and registered vs/hs 0, with reset taking priority over ce_pix.
REQ-033 SHALL discard the current partial frame on a reset mid-frame, and count the first frame only from the next vs_in rising edge.

Configuration
REQ-034 SHALL, when ARTICOLOR_CTRL_PHASE_EN is defined, implement the parity tracking and phase_inv update of REQ-019, REQ-020 and REQ-031.
REQ-035 SHALL, when ARTICOLOR_CTRL_PHASE_EN is undefined, tie phase_inv to 0, omit the parity and even/odd counters, and leave all other behaviour identical.

Structure
REQ-036 SHALL place the state enum (OFF, ARM, ON, DISARM), the mode encodings and the default thresholds in package articolor_pkg.
REQ-037 SHALL implement pixel classification and triplet detection in sub-module articolor_detect, which outputs a triplet strobe and middle-pixel colour per ce_pix.

Verification
REQ-038 SHALL verify that in auto mode, 4 frames of alternating W/B columns (1000 triplets per line for 200 lines) raise enable after the 4th vs rising edge and set frame_cnt=65535 (saturated).
REQ-039 SHALL verify that in ON, a solid black frame moves to DISARM with enable still 1, 8 clean frames in a row drop enable, and an artifact frame at clean frame 5 returns to ON.
REQ-040 SHALL verify that in ARM after 2 artifact frames, a frame of 1000 triplets (hold) returns to OFF with enable staying 0.
REQ-041 SHALL verify that with the pattern shifted by one pixel relative to hs_in, phase_inv toggles 0->1 at the next boundary, and stays 0 when ARTICOLOR_CTRL_PHASE_EN is undefined.
REQ-042 SHALL verify that mode=01 gives enable=1 one ce_pix later regardless of state, and mode=00 gives enable=0.
REQ-043 SHALL verify that reset asserted mid-frame in ON gives all outputs 0 on the next clk, and the W-B-W pattern split across hbl_in is not counted.
